// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with an issue scoreboard.
//
// Two combinational read ports, one write port and a busy-bit scoreboard that
// tracks destination registers with results still pending. After reset the
// array is zeroed by a CLEAR sequence of NREG cycles; ready_o rises once it has
// finished. The array itself has no reset; only the control state and the
// scoreboard are reset asynchronously.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ra1_i/ra2_i            read addresses; rd1_o/rd2_o read data
//   we_i, wa_i, wd_i       write enable, address, data
//   iss_valid_i, iss_rd_i  issue strobe and destination register (sets busy)
//   flush_i                clear every busy bit
//   busy1_o/busy2_o        busy bit of ra1_i/ra2_i
//   ready_o                high once the CLEAR sequence has finished
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to a
// read port reading the register being written. Without it, reads return the
// pre-write value until the next edge.
module regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,
    input  logic            flush_i,
    output logic            busy1_o,
    output logic            busy2_o,
    output logic            ready_o
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] mem_q [NREG];

    logic run;
    logic wr_valid;
    logic iss_set;
    logic ra1_ok, ra2_ok;

    assign run = (state_q == StRun);

    // Register 0 and out-of-range addresses are never written, issued or read.
    assign wr_valid = run && we_i && (wa_i != '0) && (32'(wa_i) < NREG);
    assign iss_set  = run && iss_valid_i && (iss_rd_i != '0) && (32'(iss_rd_i) < NREG);
    assign ra1_ok   = run && (ra1_i != '0) && (32'(ra1_i) < NREG);
    assign ra2_ok   = run && (ra2_i != '0) && (32'(ra2_i) < NREG);

    // Control FSM: CLEAR walks cnt_q over every register, then RUN until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                StClear: begin
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                    cnt_q <= cnt_q + AW'(1);
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; CLEAR zeroes it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_valid) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Scoreboard: write clears, issue sets (set wins), flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (wr_valid) begin
            busy_d[wa_i] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (run && flush_i) begin
            busy_d = '0;
        end
    end

    always_comb begin
        rd1_o   = '0;
        rd2_o   = '0;
        busy1_o = 1'b0;
        busy2_o = 1'b0;
        if (ra1_ok) begin
            rd1_o   = mem_q[ra1_i];
            busy1_o = busy_q[ra1_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (wa_i == ra1_i)) begin
                rd1_o = wd_i;
            end
`endif
        end
        if (ra2_ok) begin
            rd2_o   = mem_q[ra2_i];
            busy2_o = busy_q[ra2_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (wa_i == ra2_i)) begin
                rd2_o = wd_i;
            end
`endif
        end
    end

    assign ready_o = ready_q;

endmodule
